// File: rtl/fifo_queue_pkg.sv
// Shared constants and helpers for the fifo_queue block.
// Optional feature macro: FIFO_QUEUE_FWFT_EN (first-word-fall-through read mode).
package fifo_queue_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Occupancy needs one extra bit so that count can reach DEPTH itself.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_queue_mem.sv
// Storage array for fifo_queue: one write port and a registered read port,
// plus a combinational head read port when FIFO_QUEUE_FWFT_EN is defined.
module fifo_queue_mem
  import fifo_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
`ifdef FIFO_QUEUE_FWFT_EN
  ,
  input  logic [AW-1:0]    caddr,
  output logic [WIDTH-1:0] cdata
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // The read register is cleared on reset so the popped-data output starts at zero.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

`ifdef FIFO_QUEUE_FWFT_EN
  assign cdata = mem_q[caddr];
`endif

endmodule

// File: rtl/fifo_queue.sv
// Synchronous FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_QUEUE_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_queue
  import fifo_queue_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rdv_q, rdv_d;
  logic             push, pop;
  logic [WIDTH-1:0] mem_rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Acceptance looks only at the registered flags, so a pop never frees room
  // for a push in the same cycle and vice versa.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    rdv_d   = pop;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_en && full)  ovf_d = 1'b1;
    if (rd_en && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rdv_q   <= rdv_d;
    end
  end

`ifdef FIFO_QUEUE_FWFT_EN
  logic [WIDTH-1:0] head_data;

  fifo_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (push),
    .waddr (wptr_q),
    .wdata (wr_data),
    .re    (1'b0),
    .raddr (rptr_q),
    .rdata (mem_rdata),
    .caddr (rptr_q),
    .cdata (head_data)
  );

  // Head entry is presented directly; zero while empty so reset reads as 0.
  assign rd_data  = empty ? '0 : head_data;
  assign rd_valid = ~empty;
`else
  fifo_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (push),
    .waddr (wptr_q),
    .wdata (wr_data),
    .re    (pop),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  assign rd_data  = mem_rdata;
  assign rd_valid = rdv_q;
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// Directed scoreboard bench for fifo_queue in its default (registered-read) build.
module tb_fifo_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;

  fifo_queue #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  logic [7:0] last_rd;
  logic       m_ovf;
  logic       m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".count"},    32'(count),        32'(n));
    chk({tag, ".empty"},    32'(empty),        32'(n == 0));
    chk({tag, ".full"},     32'(full),         32'(n == DEPTH));
    chk({tag, ".aempty"},   32'(almost_empty), 32'(n <= 2));
    chk({tag, ".afull"},    32'(almost_full),  32'(n >= 14));
    chk({tag, ".overflow"}, 32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},32'(underflow),    32'(m_udf));
  endtask

  // One clock with the given request; expectations come from the queue model.
  task automatic cycle(input string tag, input logic w, input logic [7:0] d, input logic r);
    logic exp_pop, exp_push;
    logic [7:0] popped;
    exp_pop  = r && (sb.size() > 0);
    exp_push = w && (sb.size() < DEPTH);
    if (w && sb.size() == DEPTH) m_ovf = 1'b1;
    if (r && sb.size() == 0)     m_udf = 1'b1;
    popped = last_rd;
    if (exp_pop) popped = sb.pop_front();
    if (exp_push) sb.push_back(d);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_pop));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(popped));
    last_rd = popped;
    chk_status(tag);
  endtask

  // Reset asserted together with push and pop requests; reset must win.
  task automatic do_reset(input string tag);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    rd_en   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sb.delete();
    last_rd = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, ".rd_data"},  32'(rd_data),  32'h0);
    chk_status(tag);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    last_rd = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    // Basic order
    cycle("push1", 1'b1, 8'h01, 1'b0);
    cycle("push2", 1'b1, 8'h02, 1'b0);
    cycle("push3", 1'b1, 8'h03, 1'b0);
    cycle("idle",  1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle("pop123", 1'b0, 8'h00, 1'b1);
    cycle("hold", 1'b0, 8'h00, 1'b0);

    // Fill to full, overflow, push+pop at full, drain
    do_reset("rst1");
    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(8'h10 + i), 1'b0);
    cycle("ovf_push", 1'b1, 8'h55, 1'b0);
    cycle("full_pp",  1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 15; i++) cycle("drain", 1'b0, 8'h00, 1'b1);

    // Pop on empty with simultaneous push
    do_reset("rst2");
    cycle("udf_pp",  1'b1, 8'hAA, 1'b1);
    cycle("pop_aa",  1'b0, 8'h00, 1'b1);

    // Steady-state push+pop across pointer wrap
    do_reset("rst3");
    for (int i = 0; i < 8; i++) cycle("fill8", 1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 8; i++) cycle("drain8", 1'b0, 8'h00, 1'b1);

    // Almost flags, then reset mid-stream clears sticky errors
    cycle("udf_set", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 14; i++) cycle("fill14", 1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 12; i++) cycle("pop12", 1'b0, 8'h00, 1'b1);
    cycle("mid_pp", 1'b1, 8'hC0, 1'b1);
    do_reset("rst_mid");
    cycle("post_push", 1'b1, 8'h5A, 1'b0);
    cycle("post_pop",  1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_queue.md
FIFO_QUEUE -- requirements
Module: fifo_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of entries (power of two, 4..256).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full asserts when count >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning almost_empty asserts when count <= AE_LEVEL.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1, a push request.
REQ-008 The block SHALL have port wr_data, input, WIDTH, the push data.
REQ-009 The block SHALL have port rd_en, input, 1, a pop request.
REQ-010 The block SHALL have port rd_data, output, WIDTH, the popped or head data.
REQ-011 The block SHALL have port rd_valid, output, 1, qualifying rd_data.
REQ-012 The block SHALL have ports empty, full, almost_empty and almost_full, each output, 1, as status flags.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1, the current occupancy.
REQ-014 The block SHALL have ports overflow and underflow, each output, 1, as sticky error flags.

Function
REQ-015 A push SHALL be accepted when wr_en=1 and full=0; wr_data is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-016 A pop SHALL be accepted when rd_en=1 and empty=0; the read pointer increments modulo DEPTH.
REQ-017 A simultaneous accepted push and pop SHALL leave count unchanged and update both pointers.
REQ-018 When full=1, wr_en SHALL be rejected even if a pop is accepted in the same cycle; overflow is set and storage is unchanged.
REQ-019 When empty=1, rd_en SHALL be rejected even if a push is accepted in the same cycle; underflow is set.
REQ-020 count SHALL be registered; empty=(count==0), full=(count==DEPTH), and the almost flags SHALL be combinational from count, so all flags reflect a transaction on the cycle after its edge.
REQ-021 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated entries.
REQ-022 overflow and underflow SHALL hold at 1 until reset.
REQ-023 Data order SHALL be strictly first-in first-out.

Reset
REQ-024 When reset=1 at a clock edge, pointers, count, overflow, underflow, rd_valid and rd_data SHALL clear to 0, leaving empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-025 A reset mid-operation SHALL take priority over any push or pop in the same cycle; storage contents need not be cleared.

Configuration
REQ-026 With macro FIFO_QUEUE_FWFT_EN defined, the block SHALL operate in first-word-fall-through mode: rd_data shows the head entry whenever empty=0, rd_valid=~empty, and an accepted pop advances to the next entry.
REQ-027 With FIFO_QUEUE_FWFT_EN undefined, rd_data SHALL be registered and update one cycle after an accepted pop, with rd_valid=1 for exactly that cycle; otherwise rd_data holds its last value.

Structure
REQ-028 A shared package fifo_queue_pkg SHALL hold the count-width function and the default WIDTH/DEPTH constants.
REQ-029 The storage array SHALL be a sub-module fifo_queue_mem: one write port and one synchronous read port, with a combinational read port used only in FWFT mode.

Verification (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-030 Reset, then push 0x01, 0x02, 0x03, then pop three times -> rd_data=0x01, 0x02, 0x03 in order, and empty=1 afterwards.
REQ-031 Push 16 entries 0x10..0x1F -> full=1 and count=16; a 17th push -> overflow=1 and the data is unchanged.
REQ-032 Pop on empty with a simultaneous push of 0xAA -> underflow=1, count=1, and the next pop returns 0xAA.
REQ-033 Fill to 8 entries, then hold wr_en=rd_en=1 for 20 cycles with incrementing data -> count stays 8, ordering is preserved across pointer wrap, and there are no errors.
REQ-034 At count=14, almost_full=1; after popping to 2, almost_empty=1; asserting reset mid-stream -> count=0, empty=1, and overflow=underflow=0.
